// File: rtl/inert_resp_pkg.sv
// ----------------------------------------------------------------------------
// inert_resp_pkg
// Shared definitions for the inertial-sensor SPI responder model:
//   - frame geometry and bit-counter limits
//   - register-map addresses and the fixed WHO_AM_I identity value
//   - FSM state encoding
//   - sample bundle (six 16-bit axis values)
//   - frame-done descriptor passed from the SPI front end to the register map
// ----------------------------------------------------------------------------
package inert_resp_pkg;

    localparam int          FRAME_W  = 16;
    localparam int          CNT_W    = 5;
    // Bit count saturates one past a full frame so an overrun can never
    // wrap back around to look like a good 16-bit frame.
    localparam logic [4:0]  CNT_CMD  = 5'd8;
    localparam logic [4:0]  CNT_FULL = 5'd16;
    localparam logic [4:0]  CNT_SAT  = 5'd17;

    // Register map
    localparam logic [6:0]  ADDR_INT_CTRL = 7'h0D;
    localparam logic [6:0]  ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0]  ADDR_CTRL1_XL = 7'h10;
    localparam logic [6:0]  ADDR_CTRL2_G  = 7'h11;
    localparam logic [6:0]  ADDR_CTRL5    = 7'h14;
    localparam logic [6:0]  ADDR_PTCH_L   = 7'h22;
    localparam logic [6:0]  ADDR_PTCH_H   = 7'h23;
    localparam logic [6:0]  ADDR_ROLL_L   = 7'h24;
    localparam logic [6:0]  ADDR_ROLL_H   = 7'h25;
    localparam logic [6:0]  ADDR_YAW_L    = 7'h26;
    localparam logic [6:0]  ADDR_YAW_H    = 7'h27;
    localparam logic [6:0]  ADDR_AX_L     = 7'h28;
    localparam logic [6:0]  ADDR_AX_H     = 7'h29;
    localparam logic [6:0]  ADDR_AY_L     = 7'h2A;
    localparam logic [6:0]  ADDR_AY_H     = 7'h2B;
    localparam logic [6:0]  ADDR_AZ_L     = 7'h2C;
    localparam logic [6:0]  ADDR_AZ_H     = 7'h2D;

    localparam logic [7:0]  WHO_AM_I_VAL  = 8'h6A;
    localparam int          INT_EN_BIT    = 1;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    typedef struct packed {
        logic [15:0] ptch;
        logic [15:0] roll;
        logic [15:0] yaw;
        logic [15:0] ax;
        logic [15:0] ay;
        logic [15:0] az;
    } sample_t;

    // Decoded frame as seen at SS_n rise; good means exactly 16 bits arrived.
    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       good;
    } frame_t;

endpackage

// File: rtl/spi_resp_phy.sv
// ----------------------------------------------------------------------------
// spi_resp_phy
// SPI mode-0 responder front end, oversampling SS_n/SCLK/MOSI on clk.
//   clk, rst_n     system clock, async active-low reset
//   ss_n_i         SPI select (async)
//   sclk_i         SPI clock (async), sample on rise, change on fall
//   mosi_i         master-out data (async), MSB first
//   rd_data_i      register-map read data for rd_addr_o (combinational)
//   rd_addr_o      address field of the command byte being received
//   miso_o         responder-out data, MSB first
//   busy_o         a frame is in progress (FSM not IDLE)
//   frm_done_o     one-clk strobe on SS_n rise ending a frame
//   frm_o          decoded frame {wr, rd, addr, wdata, good}, valid with frm_done_o
// ----------------------------------------------------------------------------
module spi_resp_phy
    import inert_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss_n_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic [7:0] rd_data_i,
    output logic [6:0] rd_addr_o,
    output logic       miso_o,
    output logic       busy_o,
    output logic       frm_done_o,
    output frame_t     frm_o
);

    // Newest and oldest of the last two synchronizer stages.
    localparam int NEW = SYNC_STAGES - 2;
    localparam int OLD = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_q, rx_d;
    logic [7:0]         tx_q, tx_d;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_low, mosi_s;

    // ------------------------------------------------------------------
    // Synchronizers; SS_n idles high so its chain resets to ones.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   ss_n_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign sclk_rise =  sclk_sync_q[NEW] & ~sclk_sync_q[OLD];
    assign sclk_fall = ~sclk_sync_q[NEW] &  sclk_sync_q[OLD];
    assign ss_fall   = ~ss_sync_q[NEW]   &  ss_sync_q[OLD];
    assign ss_rise   =  ss_sync_q[NEW]   & ~ss_sync_q[OLD];
    assign ss_low    = ~ss_sync_q[NEW];
    // MOSI taken from the same stage as the SCLK edge so it is aligned.
    assign mosi_s    =  mosi_sync_q[NEW];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (sclk_rise && cnt_q == CNT_CMD - 5'd1) state_d = DATA;
            DATA:    state_d = DATA;
            default: state_d = IDLE;
        endcase
        // Deselect ends the frame from any state.
        if (ss_rise) state_d = IDLE;
    end

    // FSM: outputs
    always_comb begin
        miso_o     = (state_q == DATA) & tx_q[7];
        busy_o     = (state_q != IDLE);
        frm_done_o = ss_rise & (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Bit counter and shift registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rx_q  <= '0;
            tx_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rx_q  <= rx_d;
            tx_q  <= tx_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        rx_d  = rx_q;
        tx_d  = tx_q;
        if (state_q == IDLE) begin
            if (ss_fall) begin
                cnt_d = '0;
                rx_d  = '0;
                tx_d  = '0;
            end
        end else if (ss_low) begin
            if (sclk_rise) begin
                rx_d = {rx_q[FRAME_W-2:0], mosi_s};
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
            end
            if (sclk_fall && state_q == DATA) begin
                // First fall after the command byte: rx_q[7] is R/Wn.
                if (cnt_q == CNT_CMD)     tx_d = rx_q[7] ? rd_data_i : 8'h00;
                else if (cnt_q > CNT_CMD) tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    // Until the 8th rise, rx_q[6:0] is incomplete, but it is only consumed
    // on the fall that follows the 8th rise.
    assign rd_addr_o = rx_q[6:0];

    always_comb begin
        frm_o.wr    = ~rx_q[15];
        frm_o.rd    =  rx_q[15];
        frm_o.addr  =  rx_q[14:8];
        frm_o.wdata =  rx_q[7:0];
        frm_o.good  = (cnt_q == CNT_FULL);
    end

endmodule

// File: rtl/inert_sensor_spi_resp.sv
// ----------------------------------------------------------------------------
// inert_sensor_spi_resp
// SPI responder model of a 6-axis inertial sensor: byte-wide register map
// behind 16-bit SPI frames, sample capture on smp_vld, data-ready interrupt.
//   clk, rst_n        system clock (SCLK period >= 8 clk), async active-low reset
//   SS_n, SCLK, MOSI  SPI mode-0 inputs from the master
//   MISO              SPI responder output
//   INT               data-ready interrupt, active-high level
//   smp_vld           one-clk pulse: new values on the six axis inputs
//   ptch_rt, roll_rt, yaw_rt, ax, ay, az   signed 16-bit axis values
// ----------------------------------------------------------------------------
module inert_sensor_spi_resp
    import inert_resp_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] INT_CTRL_RST = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    output logic               INT,
    input  logic               smp_vld,
    input  logic signed [15:0] ptch_rt,
    input  logic signed [15:0] roll_rt,
    input  logic signed [15:0] yaw_rt,
    input  logic signed [15:0] ax,
    input  logic signed [15:0] ay,
    input  logic signed [15:0] az
);

    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, frm_done;
    frame_t     frm;

    logic [7:0] int_ctrl_q, int_ctrl_d;
    logic [7:0] ctrl1_xl_q, ctrl1_xl_d;
    logic [7:0] ctrl2_g_q,  ctrl2_g_d;
    logic [7:0] ctrl5_q,    ctrl5_d;
    sample_t    data_q,     data_d;
    sample_t    pend_q,     pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       int_q,      int_d;

    sample_t    smp_in;
    logic       commit, latch, int_clr;

    spi_resp_phy #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_phy (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_n_i     (SS_n),
        .sclk_i     (SCLK),
        .mosi_i     (MOSI),
        .rd_data_i  (rd_data),
        .rd_addr_o  (rd_addr),
        .miso_o     (MISO),
        .busy_o     (busy),
        .frm_done_o (frm_done),
        .frm_o      (frm)
    );

    always_comb begin
        smp_in.ptch = ptch_rt;
        smp_in.roll = roll_rt;
        smp_in.yaw  = yaw_rt;
        smp_in.ax   = ax;
        smp_in.ay   = ay;
        smp_in.az   = az;
    end

    // ------------------------------------------------------------------
    // Register read mux (feeds the TX load on the fall after the command)
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_INT_CTRL: rd_data = int_ctrl_q;
            ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
            ADDR_CTRL1_XL: rd_data = ctrl1_xl_q;
            ADDR_CTRL2_G:  rd_data = ctrl2_g_q;
            ADDR_CTRL5:    rd_data = ctrl5_q;
            ADDR_PTCH_L:   rd_data = data_q.ptch[7:0];
            ADDR_PTCH_H:   rd_data = data_q.ptch[15:8];
            ADDR_ROLL_L:   rd_data = data_q.roll[7:0];
            ADDR_ROLL_H:   rd_data = data_q.roll[15:8];
            ADDR_YAW_L:    rd_data = data_q.yaw[7:0];
            ADDR_YAW_H:    rd_data = data_q.yaw[15:8];
            ADDR_AX_L:     rd_data = data_q.ax[7:0];
            ADDR_AX_H:     rd_data = data_q.ax[15:8];
            ADDR_AY_L:     rd_data = data_q.ay[7:0];
            ADDR_AY_H:     rd_data = data_q.ay[15:8];
            ADDR_AZ_L:     rd_data = data_q.az[7:0];
            ADDR_AZ_H:     rd_data = data_q.az[15:8];
            default:       rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Commit, sampling and interrupt next-state
    // ------------------------------------------------------------------
    always_comb begin
        int_ctrl_d = int_ctrl_q;
        ctrl1_xl_d = ctrl1_xl_q;
        ctrl2_g_d  = ctrl2_g_q;
        ctrl5_d    = ctrl5_q;
        data_d     = data_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        int_d      = int_q;
        latch      = 1'b0;

        // Short or overrun frames are dropped without any side effect.
        commit = frm_done & frm.good;

        if (commit && frm.wr) begin
            case (frm.addr)
                ADDR_INT_CTRL: int_ctrl_d = frm.wdata;
                ADDR_CTRL1_XL: ctrl1_xl_d = frm.wdata;
                ADDR_CTRL2_G:  ctrl2_g_d  = frm.wdata;
                ADDR_CTRL5:    ctrl5_d    = frm.wdata;
                default:       ;
            endcase
        end

        int_clr = commit & ((frm.rd & (frm.addr == ADDR_AZ_H)) |
                            (frm.wr & (frm.addr == ADDR_INT_CTRL) & ~frm.wdata[INT_EN_BIT]));

        // While a frame is open, samples are parked so a read never sees a
        // torn register pair; the newest park wins. The parked sample is
        // applied on the first idle clock, i.e. the one after the commit.
        if (busy) begin
            if (smp_vld) begin
                pend_d     = smp_in;
                pend_vld_d = 1'b1;
            end
        end else if (smp_vld) begin
            latch      = 1'b1;
            data_d     = smp_in;
            pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
            latch      = 1'b1;
            data_d     = pend_q;
            pend_vld_d = 1'b0;
        end

        // Set has priority over clear.
        if (latch && int_ctrl_q[INT_EN_BIT]) int_d = 1'b1;
        else if (int_clr)                    int_d = 1'b0;
    end

    // NOTE: every register here, including the sample and pending buffers, is reset so post-reset reads are defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ctrl_q <= INT_CTRL_RST;
            ctrl1_xl_q <= 8'h00;
            ctrl2_g_q  <= 8'h00;
            ctrl5_q    <= 8'h00;
            data_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            int_ctrl_q <= int_ctrl_d;
            ctrl1_xl_q <= ctrl1_xl_d;
            ctrl2_g_q  <= ctrl2_g_d;
            ctrl5_q    <= ctrl5_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            int_q      <= int_d;
        end
    end

    assign INT = int_q;

endmodule

// File: tb/tb_inert_sensor_spi_resp.sv
// ----------------------------------------------------------------------------
// tb_inert_sensor_spi_resp
// Self-checking bench for inert_sensor_spi_resp: a table of single SPI
// frames with expected MISO words, plus hand-built sequences for sampling,
// interrupt, pending-sample, abort and mid-frame reset behaviour.
// ----------------------------------------------------------------------------
module tb_inert_sensor_spi_resp;

    localparam int HALF = 5;   // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n, SCLK, MOSI, MISO, INT, smp_vld;
    logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay, az;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       name;
        logic [15:0] frame;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    inert_sensor_spi_resp #(
        .SYNC_STAGES  (2),
        .INT_CTRL_RST (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .INT     (INT),
        .smp_vld (smp_vld),
        .ptch_rt (ptch_rt),
        .roll_rt (roll_rt),
        .yaw_rt  (yaw_rt),
        .ax      (ax),
        .ay      (ay),
        .az      (az)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        SS_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // One mode-0 bit: drive MOSI, sample MISO just before the rise.
    task automatic spi_bit(input logic b, output logic m);
        MOSI = b;
        wait_clk(HALF);
        m    = MISO;
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] r);
        logic m;
        r = '0;
        ss_low();
        for (int i = 0; i < nbits; i++) begin
            spi_bit((i < 16) ? w[15-i] : 1'b0, m);
            if (i < 16) r[15-i] = m;
        end
        ss_high();
    endtask

    // Push expectation, run the frame, pop and compare against MISO.
    task automatic sb_frame(input string nm, input logic [15:0] w, input logic [15:0] exp);
        sb_t         e;
        logic [15:0] r;
        e.name = nm;
        e.exp  = exp;
        sb_q.push_back(e);
        spi_frame(w, 16, r);
        e = sb_q.pop_front();
        check(e.name, r, e.exp);
    endtask

    task automatic pulse_smp();
        smp_vld = 1'b1;
        @(negedge clk);
        smp_vld = 1'b0;
    endtask

    function automatic void add_vec(input string n, input logic [15:0] f, input logic [15:0] e);
        vec_t v;
        v.name  = n;
        v.frame = f;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r;
        logic        m;
        sb_t         e;

        add_vec("rd_who_am_i",      16'h8F00, 16'h006A);
        add_vec("rd_unmapped_3f",   16'hBF00, 16'h0000);
        add_vec("rd_int_ctrl_rst",  16'h8D00, 16'h0000);
        add_vec("rd_ctrl1_rst",     16'h9000, 16'h0000);
        add_vec("wr_ctrl1_miso",    16'h1077, 16'h0000);
        add_vec("rd_ctrl1",         16'h9000, 16'h0077);
        add_vec("wr_ctrl2_miso",    16'h1155, 16'h0000);
        add_vec("rd_ctrl2",         16'h9100, 16'h0055);
        add_vec("wr_ctrl5_miso",    16'h1499, 16'h0000);
        add_vec("rd_ctrl5",         16'h9400, 16'h0099);
        add_vec("wr_who_ro",        16'h0F12, 16'h0000);
        add_vec("rd_who_after_wr",  16'h8F00, 16'h006A);
        add_vec("wr_data_ro",       16'h2233, 16'h0000);
        add_vec("rd_ptch_l_rst",    16'hA200, 16'h0000);
        add_vec("wr_unmapped",      16'h3FAA, 16'h0000);
        add_vec("rd_unmapped_3f_2", 16'hBF00, 16'h0000);
        add_vec("rd_who_dontcare",  16'h8FFF, 16'h006A);
        add_vec("wr_int_ctrl",      16'h0D02, 16'h0000);
        add_vec("rd_int_ctrl",      16'h8D00, 16'h0002);

        // Reset
        rst_n   = 1'b0;
        SS_n    = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        smp_vld = 1'b0;
        ptch_rt = 16'h1234; roll_rt = 16'h5678; yaw_rt = 16'h9ABC;
        ax      = 16'h1111; ay      = 16'h2222; az     = 16'h3333;
        wait_clk(4);
        check("reset_miso", {15'd0, MISO}, 16'h0000);
        check("reset_int",  {15'd0, INT},  16'h0000);
        rst_n = 1'b1;
        wait_clk(4);

        foreach (vecs[i]) sb_frame(vecs[i].name, vecs[i].frame, vecs[i].exp);

        // Sample with INT enabled: INT rises within one clk of smp_vld.
        check("int_before_smp", {15'd0, INT}, 16'h0000);
        pulse_smp();
        check("int_after_smp", {15'd0, INT}, 16'h0001);
        sb_frame("rd_ptch_h", 16'hA300, 16'h0012);
        sb_frame("rd_ptch_l", 16'hA200, 16'h0034);
        sb_frame("rd_yaw_h",  16'hA700, 16'h009A);
        sb_frame("rd_az_l",   16'hAC00, 16'h0033);
        check("int_after_az_l", {15'd0, INT}, 16'h0001);
        sb_frame("rd_az_h",   16'hAD00, 16'h0033);
        check("int_clr_az_h", {15'd0, INT}, 16'h0000);

        // Sample mid-frame: read returns the old byte, latch follows SS_n rise.
        ax = 16'hBEEF;
        e.name = "rd_ax_l_midframe";
        e.exp  = 16'h0011;
        sb_q.push_back(e);
        r = '0;
        ss_low();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hA800;
            if (i == 4) pulse_smp();
            spi_bit(w[15-i], m);
            r[15-i] = m;
        end
        check("int_pending", {15'd0, INT}, 16'h0000);
        ss_high();
        e = sb_q.pop_front();
        check(e.name, r, e.exp);
        check("int_after_pend", {15'd0, INT}, 16'h0001);
        sb_frame("rd_ax_h_new", 16'hA900, 16'h00BE);
        sb_frame("rd_ax_l_new", 16'hA800, 16'h00EF);

        // Two samples inside one frame: the newer one wins.
        r = '0;
        ss_low();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h8F00;
            if (i == 3)  begin ay = 16'hAAAA; pulse_smp(); end
            if (i == 11) begin ay = 16'hBBBB; pulse_smp(); end
            spi_bit(w[15-i], m);
            r[15-i] = m;
        end
        ss_high();
        check("rd_who_dbl_smp", r, 16'h006A);
        sb_frame("rd_ay_h_newest", 16'hAB00, 16'h00BB);
        sb_frame("rd_ay_l_newest", 16'hAA00, 16'h00BB);

        // INT cleared by writing INT_CTRL with bit1 = 0.
        check("int_before_wr_clr", {15'd0, INT}, 16'h0001);
        sb_frame("wr_int_ctrl_0", 16'h0D00, 16'h0000);
        check("int_clr_by_wr", {15'd0, INT}, 16'h0000);
        sb_frame("rd_int_ctrl_0", 16'h8D00, 16'h0000);
        sb_frame("wr_int_ctrl_2", 16'h0D02, 16'h0000);

        // Aborted frames: 10 clocks and 17 clocks are both discarded.
        spi_frame(16'h10AB, 10, r);
        sb_frame("rd_ctrl1_after_short", 16'h9000, 16'h0077);
        spi_frame(16'h10AB, 17, r);
        sb_frame("rd_ctrl1_after_over",  16'h9000, 16'h0077);
        sb_frame("wr_ctrl1_full",        16'h10AB, 16'h0000);
        sb_frame("rd_ctrl1_after_full",  16'h9000, 16'h00AB);

        // Reset in the data phase of a read whose first data bit is 1.
        pulse_smp();
        check("int_before_rst", {15'd0, INT}, 16'h0001);
        ss_low();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'hA900;
            spi_bit(w[15-i], m);
        end
        wait_clk(HALF);
        check("miso_before_rst", {15'd0, MISO}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("miso_in_rst", {15'd0, MISO}, 16'h0000);
        check("int_in_rst",  {15'd0, INT},  16'h0000);
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        sb_frame("rd_int_ctrl_post_rst", 16'h8D00, 16'h0000);
        sb_frame("rd_ctrl1_post_rst",    16'h9000, 16'h0000);
        sb_frame("rd_ax_h_post_rst",     16'hA900, 16'h0000);
        sb_frame("rd_who_post_rst",      16'h8F00, 16'h006A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
